led_flow_monitor: RTL and testbench

Receive-side monitor for the 8-bit flowing-LED bus. It samples the LED vector driven by the flowing-LED generator and decodes the one-hot position. It checks that each change is a legal single-step move, measures how many cycles each position is held, and raises a sticky error on any protocol violation. It sits beside the generator in the top level and in benches as a self-checking observer.

---
 rtl/led_flow_pkg.sv | 16 +
 rtl/led_onehot_dec.sv | 28 ++
 rtl/led_flow_monitor.sv | 187 ++++++++++++++++++
 tb/tb_led_flow_monitor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/led_flow_pkg.sv
// Shared encodings for the flowing-LED receive monitor: FSM state
// codes and the 2-bit fault codes reported on err_code_o.
package led_flow_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_TRACK = 2'd1;
  localparam state_t ST_FAULT = 2'd2;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_STEP    = 2'b10;
  localparam logic [1:0] ERR_STALL   = 2'b11;

endpackage

// File: rtl/led_onehot_dec.sv
// Combinational one-hot decoder for LED vectors. legal is high when
// exactly one bit of vec is set; idx is the index of that bit.
module led_onehot_dec #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         vec,
  output logic                     legal,
  output logic [$clog2(WIDTH)-1:0] idx
);

  localparam int IDX_W = $clog2(WIDTH);

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
  always_comb begin
    legal = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
  end

  // Index of the set bit; only meaningful when legal is high.
  // NOTE: every variable assigned in always_comb gets a default first so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/led_flow_monitor.sv
// Receive-side observer for the flowing-LED bus. Locks onto the first
// legal one-hot sample, then checks every change is a single legal step,
// measures dwell per position and raises a sticky fault on violations.
// Build option: define LED_FLOW_PINGPONG_EN to accept steps in either
// direction without wrap-around; dir_o then tracks the last step.
module led_flow_monitor
  import led_flow_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIR     = 0,
  parameter int TIMEOUT = 50000000,
  parameter int CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [WIDTH-1:0]         led_i,
  input  logic                     clr_i,
  output logic                     valid_o,
  output logic [$clog2(WIDTH)-1:0] pos_o,
  output logic [15:0]              step_cnt_o,
  output logic [CNT_W-1:0]         dwell_o,
  output logic                     dir_o,
  output logic                     err_o,
  output logic [1:0]               err_code_o
);

  localparam int               IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] POS_MAX  = IDX_W'(WIDTH - 1);
  // The stall fires on the sample that would bring the count to TIMEOUT.
  localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   led_q;
  logic               legal;
  logic [IDX_W-1:0]   idx;
  logic               change;
  logic [IDX_W-1:0]   pos_inc, pos_dec;
  logic               step_up, step_down, step_legal;
  logic               step_ok, fault_det;
  logic [1:0]         fault_code;
  logic [CNT_W-1:0]   dwell_cnt, cnt_d;
  logic [IDX_W-1:0]   pos_d;
  logic [15:0]        step_d;
  logic [CNT_W-1:0]   dwell_d;
  logic [1:0]         code_d;
  logic               dir_d;

  led_onehot_dec #(.WIDTH(WIDTH)) u_dec (
    .vec   (led_i),
    .legal (legal),
    .idx   (idx)
  );

  assign change = (led_i != led_q);

  // Neighbouring positions of the current one, with modulo-WIDTH wrap.
  always_comb begin
    pos_inc = (pos_o == POS_MAX) ? '0 : pos_o + 1'b1;
    pos_dec = (pos_o == '0) ? POS_MAX : pos_o - 1'b1;
  end

`ifdef LED_FLOW_PINGPONG_EN
  // Either neighbour is a legal step, but the ends do not wrap.
  always_comb begin
    step_up   = (pos_o != POS_MAX) && (idx == pos_inc);
    step_down = (pos_o != '0) && (idx == pos_dec);
  end
`else
  // Only the neighbour in the configured flow direction is legal.
  always_comb begin
    step_up   = (DIR == 0) && (idx == pos_inc);
    step_down = (DIR != 0) && (idx == pos_dec);
  end
`endif

  assign step_legal = step_up | step_down;

  // Classify the current sample while tracking: good step, fault, or hold.
  always_comb begin
    step_ok    = 1'b0;
    fault_det  = 1'b0;
    fault_code = ERR_NONE;
    if (change) begin
      if (!legal) begin
        fault_det  = 1'b1;
        fault_code = ERR_ILLEGAL;
      end else if (step_legal) begin
        step_ok = 1'b1;
      end else begin
        fault_det  = 1'b1;
        fault_code = ERR_STEP;
      end
    end else if (dwell_cnt == STALL_AT) begin
      fault_det  = 1'b1;
      fault_code = ERR_STALL;
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a clear always wins and forces a fresh relock.
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (legal) state_d = ST_TRACK;
        ST_TRACK: if (fault_det) state_d = ST_FAULT;
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and the dwell counter.
  always_comb begin
    pos_d   = pos_o;
    step_d  = step_cnt_o;
    dwell_d = dwell_o;
    cnt_d   = dwell_cnt;
    code_d  = err_code_o;
    dir_d   = dir_o;
    if (clr_i) begin
      cnt_d  = '0;
      code_d = ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (legal) begin
            pos_d  = idx;
            step_d = '0;
            cnt_d  = CNT_W'(1);
          end
        end
        ST_TRACK: begin
          if (fault_det) begin
            code_d = fault_code;
          end else if (step_ok) begin
            pos_d   = idx;
            step_d  = step_cnt_o + 16'd1;
            dwell_d = dwell_cnt;
            cnt_d   = CNT_W'(1);
`ifdef LED_FLOW_PINGPONG_EN
            dir_d   = step_down;
`endif
          end else begin
            cnt_d = dwell_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output and datapath registers; FAULT freezes pos, step count and dwell.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led_q      <= '0;
      dwell_cnt  <= '0;
      valid_o    <= 1'b0;
      pos_o      <= '0;
      step_cnt_o <= '0;
      dwell_o    <= '0;
      dir_o      <= 1'(DIR);
      err_o      <= 1'b0;
      err_code_o <= ERR_NONE;
    end else begin
      led_q      <= led_i;
      dwell_cnt  <= cnt_d;
      valid_o    <= (state_d == ST_TRACK);
      pos_o      <= pos_d;
      step_cnt_o <= step_d;
      dwell_o    <= dwell_d;
      dir_o      <= dir_d;
      err_o      <= (state_d == ST_FAULT);
      err_code_o <= code_d;
    end
  end

endmodule

// File: tb/tb_led_flow_monitor.sv
// Scoreboard bench for led_flow_monitor (WIDTH=8, DIR=0, TIMEOUT=16).
// Stimulus pushes hand-computed expected outputs tagged with the cycle
// they must appear in; a monitor pops and compares on each falling edge.
module tb_led_flow_monitor;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  led_i;
  logic        clr_i;
  logic        valid_o;
  logic [2:0]  pos_o;
  logic [15:0] step_cnt_o;
  logic [31:0] dwell_o;
  logic        dir_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  typedef struct {
    int          cyc;
    string       name;
    logic        valid;
    logic [2:0]  pos;
    logic [15:0] step;
    logic [31:0] dwell;
    logic        dir;
    logic        err;
    logic [1:0]  code;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic done = 1'b0;

  led_flow_monitor #(
    .WIDTH(8), .DIR(0), .TIMEOUT(16), .CNT_W(32)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .led_i      (led_i),
    .clr_i      (clr_i),
    .valid_o    (valid_o),
    .pos_o      (pos_o),
    .step_cnt_o (step_cnt_o),
    .dwell_o    (dwell_o),
    .dir_o      (dir_o),
    .err_o      (err_o),
    .err_code_o (err_code_o)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one sample, let the DUT capture it, return just after the edge.
  task automatic apply(input logic [7:0] v, input logic c);
    led_i = v;
    clr_i = c;
    @(posedge clk);
    #1;
    clr_i = 1'b0;
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) apply(v, 1'b0);
  endtask

  // Expected outputs for the edge just taken.
  task automatic expect_out(input string name, input logic v, input logic [2:0] p,
                            input logic [15:0] s, input logic [31:0] d,
                            input logic dr, input logic e, input logic [1:0] c);
    exp_t x;
    x.cyc = cyc; x.name = name; x.valid = v; x.pos = p; x.step = s;
    x.dwell = d; x.dir = dr; x.err = e; x.code = c;
    sb.push_back(x);
  endtask

  // Monitor: compare every due expectation against the DUT outputs.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end else begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t x;
        x = sb.pop_front();
        checks++;
        if (x.cyc != cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", x.name, x.cyc, cyc);
        end else if ({valid_o, pos_o, step_cnt_o, dwell_o, dir_o, err_o, err_code_o} !==
                     {x.valid, x.pos, x.step, x.dwell, x.dir, x.err, x.code}) begin
          errors++;
          $display("FAIL %s: got valid=%0b pos=%0d step=%0d dwell=%0d dir=%0b err=%0b code=%02b, want valid=%0b pos=%0d step=%0d dwell=%0d dir=%0b err=%0b code=%02b",
                   x.name, valid_o, pos_o, step_cnt_o, dwell_o, dir_o, err_o, err_code_o,
                   x.valid, x.pos, x.step, x.dwell, x.dir, x.err, x.code);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within 100 us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn  = 1'b0;
    led_i = 8'h01;
    clr_i = 1'b0;

    // 1. Reset holds everything at zero, then lock on the first edge.
    repeat (9) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0, 0, 0, 2'b00);
    @(posedge clk);
    #9 rstn = 1'b1;
    @(posedge clk);
    #1;
    expect_out("lock_0x01", 1, 0, 0, 0, 0, 0, 2'b00);

    // 2. Four samples per position gives dwell 4.
    hold(8'h01, 3);
    apply(8'h02, 0); expect_out("step_to_1", 1, 1, 1, 4, 0, 0, 2'b00);
    hold(8'h02, 3);
    apply(8'h04, 0); expect_out("step_to_2", 1, 2, 2, 4, 0, 0, 2'b00);

    // 3. Walk to the top and wrap to bit 0.
    apply(8'h08, 0);
    apply(8'h10, 0);
    apply(8'h20, 0);
    apply(8'h40, 0);
    apply(8'h80, 0); expect_out("walk_to_7", 1, 7, 7, 1, 0, 0, 2'b00);
    apply(8'h01, 0);
`ifdef LED_FLOW_PINGPONG_EN
    expect_out("no_wrap_pp", 0, 7, 7, 1, 0, 1, 2'b10);
    apply(8'h01, 1); expect_out("clear_after_wrap", 0, 7, 7, 1, 0, 0, 2'b00);
`else
    expect_out("wrap_to_0", 1, 0, 8, 1, 0, 0, 2'b00);
    apply(8'h01, 1); expect_out("clear_after_wrap", 0, 0, 8, 1, 0, 0, 2'b00);
`endif
    apply(8'h01, 0); expect_out("relock_0", 1, 0, 0, 1, 0, 0, 2'b00);

    // 4. Error codes, stickiness and clear behaviour.
    apply(8'h02, 0); expect_out("step_to_1b", 1, 1, 1, 1, 0, 0, 2'b00);
    apply(8'h08, 0); expect_out("wrong_step", 0, 1, 1, 1, 0, 1, 2'b10);
    apply(8'h03, 0); expect_out("code_sticky", 0, 1, 1, 1, 0, 1, 2'b10);
    apply(8'h08, 1); expect_out("clear_fault", 0, 1, 1, 1, 0, 0, 2'b00);
    apply(8'h08, 0); expect_out("relock_3", 1, 3, 0, 1, 0, 0, 2'b00);
    apply(8'h04, 1); expect_out("clear_wins", 0, 3, 0, 1, 0, 0, 2'b00);
    apply(8'h04, 0); expect_out("relock_2", 1, 2, 0, 1, 0, 0, 2'b00);
    apply(8'h0C, 0); expect_out("illegal", 0, 2, 0, 1, 0, 1, 2'b01);
    apply(8'h0C, 1); expect_out("clear_illegal", 0, 2, 0, 1, 0, 0, 2'b00);
    apply(8'h00, 0); expect_out("idle_ignores_zero", 0, 2, 0, 1, 0, 0, 2'b00);
    apply(8'h0C, 0); expect_out("idle_ignores_multi", 0, 2, 0, 1, 0, 0, 2'b00);

    // 5. Stall at the 16th held sample; 15 samples then a step is fine.
    apply(8'h10, 0); expect_out("lock_4", 1, 4, 0, 1, 0, 0, 2'b00);
    hold(8'h10, 14); expect_out("hold_15", 1, 4, 0, 1, 0, 0, 2'b00);
    apply(8'h10, 0); expect_out("stall", 0, 4, 0, 1, 0, 1, 2'b11);
    apply(8'h10, 1); expect_out("clear_stall", 0, 4, 0, 1, 0, 0, 2'b00);
    apply(8'h10, 0); expect_out("relock_4", 1, 4, 0, 1, 0, 0, 2'b00);
    hold(8'h10, 14);
    apply(8'h20, 0); expect_out("dwell_15", 1, 5, 1, 15, 0, 0, 2'b00);
    hold(8'h20, 3);
    #3 rstn = 1'b0;
    expect_out("async_reset", 0, 0, 0, 0, 0, 0, 2'b00);
    #10;
    led_i = 8'h40;
    rstn  = 1'b1;
    @(posedge clk);
    #1;
    expect_out("lock_6", 1, 6, 0, 0, 0, 0, 2'b00);

    // 6. Direction handling with and without ping-pong stepping.
`ifdef LED_FLOW_PINGPONG_EN
    apply(8'h80, 0); expect_out("pp_up", 1, 7, 1, 1, 0, 0, 2'b00);
    apply(8'h40, 0); expect_out("pp_down", 1, 6, 2, 1, 1, 0, 2'b00);
    apply(8'h80, 0); expect_out("pp_up_again", 1, 7, 3, 1, 0, 0, 2'b00);
    apply(8'h01, 0); expect_out("pp_no_wrap", 0, 7, 3, 1, 0, 1, 2'b10);
`else
    apply(8'h80, 0); expect_out("up_to_7", 1, 7, 1, 1, 0, 0, 2'b00);
    apply(8'h40, 0); expect_out("backward_step", 0, 7, 1, 1, 0, 1, 2'b10);
`endif

    repeat (2) @(posedge clk);
    #1 done = 1'b1;
  end

endmodule
